// File: rtl/output_drain_pkg.sv
// Shared helpers for the output drain buffer: beat arithmetic, lane masks and drain FSM states.
package output_drain_pkg;

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} drain_state_e;

  function automatic int beats(input int nb_channels, input int lanes);
    return (nb_channels + lanes - 1) / lanes;
  endfunction

  // Bit i is set when lane i of this beat maps onto a real channel.
  function automatic logic [31:0] lane_mask(input int beat, input int nb_channels, input int lanes);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < lanes && (beat * lanes + i) < nb_channels) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/output_entry_fifo.sv
// Synchronous FIFO of whole pixel entries; pointers carry one extra wrap bit to tell full from empty.
module output_entry_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/output_drain_buffer.sv
// Buffers whole output-channel pixels and drains each as LANES channels per beat over valid/ready.
module output_drain_buffer
  import output_drain_pkg::*;
#(
  parameter int NB_CHANNELS        = 16,
  parameter int LANES              = 3,
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 2,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128
) (
  input  logic                                  clk,
  input  logic                                  arst_n_in,
  input  logic                                  clear,
  input  logic                                  in_we,
  input  logic [NB_CHANNELS*DATA_WIDTH-1:0]     in_data,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] in_y,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [LANES*DATA_WIDTH-1:0]           out_data,
  output logic [LANES-1:0]                      out_lane_mask,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  out_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] out_y,
  output logic [$clog2(NB_CHANNELS)-1:0]        out_ch,
  output logic                                  out_last,
  output logic                                  overflow
);

  localparam int XW    = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW    = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW    = $clog2(NB_CHANNELS);
  localparam int DW    = NB_CHANNELS * DATA_WIDTH;
  localparam int EW    = DW + XW + YW;
  localparam int BEATS = beats(NB_CHANNELS, LANES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  drain_state_e      state;
  logic [BW-1:0]     beat;
  logic              full, empty, push, pop, hs, last_beat, busy_next;
  logic [CNTW-1:0]   count;
  logic [EW-1:0]     head;
  logic [DW-1:0]     head_data;
  logic [LANES*DATA_WIDTH-1:0] data_c;
  logic [LANES-1:0]  mask_c;
  logic [CW-1:0]     ch_base;

  assign in_ready  = !full;
  assign out_valid = (state == SEND);
  assign hs        = out_valid && out_ready;
  assign last_beat = (beat == BW'(BEATS - 1));
  assign push      = in_we && !full && !clear;
  assign pop       = hs && last_beat && !clear;
  // Stay busy if a pixel arrives or anything remains after this edge's pop.
  assign busy_next = push || (!empty && !(pop && count == CNTW'(1)));

  output_entry_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data ({in_y, in_x, in_data}),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head_data (head)
  );

  assign head_data = head[DW-1:0];

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state    <= EMPTY;
      beat     <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= EMPTY;
      beat     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= busy_next ? SEND : EMPTY;
      if (hs) beat <= last_beat ? '0 : beat + 1'b1;
      if (in_we && full) overflow <= 1'b1;
    end
  end

  // Lanes beyond the last channel stay zero and never index into head_data.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    data_c  = '0;
    mask_c  = LANES'(lane_mask(int'(beat), NB_CHANNELS, LANES));
    ch_base = CW'(int'(beat) * LANES);
    for (int i = 0; i < LANES; i++) begin
      if ((int'(beat) * LANES + i) < NB_CHANNELS)
        data_c[i*DATA_WIDTH +: DATA_WIDTH] = head_data[(int'(beat) * LANES + i)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign out_data      = out_valid ? data_c : '0;
  assign out_lane_mask = out_valid ? mask_c : '0;
  assign out_ch        = out_valid ? ch_base : '0;
  assign out_last      = out_valid && last_beat;
  assign out_x         = out_valid ? head[DW +: XW] : '0;
  assign out_y         = out_valid ? head[DW+XW +: YW] : '0;

endmodule

// File: tb/tb_output_drain_buffer.sv
// Directed bench for output_drain_buffer with default parameters (16 ch, 3 lanes, depth 2).
module tb_output_drain_buffer;

  logic         clk = 1'b0;
  logic         arst_n_in;
  logic         clear;
  logic         in_we;
  logic [511:0] in_data;
  logic [6:0]   in_x, in_y;
  logic         in_ready, out_valid, out_ready, out_last, overflow;
  logic [95:0]  out_data;
  logic [2:0]   out_lane_mask;
  logic [6:0]   out_x, out_y;
  logic [3:0]   out_ch;

  int total = 0;
  int bad   = 0;

  output_drain_buffer dut (
    .clk           (clk),
    .arst_n_in     (arst_n_in),
    .clear         (clear),
    .in_we         (in_we),
    .in_data       (in_data),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_lane_mask (out_lane_mask),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_ch        (out_ch),
    .out_last      (out_last),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] make_pix(input int base);
    logic [511:0] p;
    for (int k = 0; k < 16; k++) p[k*32 +: 32] = 32'(base + k);
    return p;
  endfunction

  function automatic logic [95:0] exp_data(input int base, input int b);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      if (b*3 + i < 16) r[i*32 +: 32] = 32'(base + b*3 + i);
    return r;
  endfunction

  task automatic check_beat(input string tag, input int base, input int x, input int y, input int b);
    check({tag, ".valid"}, 128'(out_valid), 128'(1));
    check({tag, ".ch"},    128'(out_ch), 128'(b*3));
    check({tag, ".data"},  128'(out_data), 128'(exp_data(base, b)));
    check({tag, ".mask"},  128'(out_lane_mask), (b < 5) ? 128'(3'b111) : 128'(3'b001));
    check({tag, ".last"},  128'(out_last), 128'(b == 5));
    check({tag, ".x"},     128'(out_x), 128'(x));
    check({tag, ".y"},     128'(out_y), 128'(y));
  endtask

  task automatic set_pix(input int base, input int x, input int y);
    in_data = make_pix(base);
    in_x    = 7'(x);
    in_y    = 7'(y);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 128'(out_valid), 128'(0));
    check({tag, ".data"},  128'(out_data), 128'(0));
    check({tag, ".mask"},  128'(out_lane_mask), 128'(0));
    check({tag, ".ch"},    128'(out_ch), 128'(0));
    check({tag, ".last"},  128'(out_last), 128'(0));
    check({tag, ".xy"},    128'({out_x, out_y}), 128'(0));
  endtask

  initial begin
    arst_n_in = 1'b0;
    clear     = 1'b0;
    in_we     = 1'b0;
    out_ready = 1'b0;
    set_pix(0, 0, 0);
    #12;
    check_idle("reset");
    check("reset.in_ready", 128'(in_ready), 128'(1));
    check("reset.overflow", 128'(overflow), 128'(0));
    arst_n_in = 1'b1;
    step();

    // Single pixel, consumer always ready
    out_ready = 1'b1;
    set_pix(100, 4, 8);
    in_we = 1'b1;
    step();
    in_we = 1'b0;
    check("single.b0_data", 128'(out_data), 128'({32'd102, 32'd101, 32'd100}));
    for (int b = 0; b < 6; b++) begin
      if (b == 5) check("single.b5_lane0", 128'(out_data[31:0]), 128'(115));
      check_beat("single", 100, 4, 8, b);
      step();
    end
    check("single.done", 128'(out_valid), 128'(0));

    // Backpressure held during beat 2
    set_pix(200, 1, 2);
    in_we = 1'b1;
    step();
    in_we = 1'b0;
    for (int b = 0; b < 2; b++) begin
      check_beat("bp", 200, 1, 2, b);
      step();
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_beat("bp.hold", 200, 1, 2, 2);
      step();
    end
    out_ready = 1'b1;
    for (int b = 2; b < 6; b++) begin
      check_beat("bp", 200, 1, 2, b);
      step();
    end
    check("bp.done", 128'(out_valid), 128'(0));

    // Fill to depth, then a dropped third capture
    out_ready = 1'b0;
    set_pix(300, 10, 11);
    in_we = 1'b1;
    step();
    set_pix(400, 12, 13);
    step();
    check("fill.in_ready", 128'(in_ready), 128'(0));
    check("fill.ovf_before", 128'(overflow), 128'(0));
    set_pix(500, 14, 15);
    step();
    in_we = 1'b0;
    check("fill.overflow", 128'(overflow), 128'(1));
    check_beat("fill.a_held", 300, 10, 11, 0);
    out_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      check_beat("fill.a", 300, 10, 11, b);
      step();
    end
    for (int b = 0; b < 6; b++) begin
      check_beat("fill.b", 400, 12, 13, b);
      step();
    end
    check("fill.done", 128'(out_valid), 128'(0));
    check("fill.ovf_sticky", 128'(overflow), 128'(1));

    // Back-to-back: B pushed on A's last-beat handshake
    set_pix(600, 20, 21);
    in_we = 1'b1;
    step();
    in_we = 1'b0;
    for (int b = 0; b < 6; b++) begin
      check_beat("b2b.a", 600, 20, 21, b);
      if (b == 5) begin
        set_pix(700, 22, 23);
        in_we = 1'b1;
      end
      step();
      in_we = 1'b0;
    end
    for (int b = 0; b < 6; b++) begin
      check_beat("b2b.b", 700, 22, 23, b);
      step();
    end
    check("b2b.done", 128'(out_valid), 128'(0));

    // clear during beat 3 with two entries queued
    out_ready = 1'b0;
    set_pix(800, 24, 25);
    in_we = 1'b1;
    step();
    set_pix(900, 26, 27);
    step();
    in_we = 1'b0;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) step();
    check_beat("clr.pre", 800, 24, 25, 3);
    clear = 1'b1;
    set_pix(950, 28, 29);
    in_we = 1'b1;
    step();
    clear = 1'b0;
    in_we = 1'b0;
    check_idle("clr.after");
    check("clr.in_ready", 128'(in_ready), 128'(1));
    check("clr.overflow", 128'(overflow), 128'(0));
    step();
    check("clr.no_push", 128'(out_valid), 128'(0));
    set_pix(1000, 30, 31);
    in_we = 1'b1;
    step();
    in_we = 1'b0;
    for (int b = 0; b < 6; b++) begin
      check_beat("clr.new", 1000, 30, 31, b);
      step();
    end
    check("clr.done", 128'(out_valid), 128'(0));

    // Asynchronous reset in the middle of a drain
    set_pix(1100, 40, 41);
    in_we = 1'b1;
    step();
    in_we = 1'b0;
    step();
    check_beat("rst.pre", 1100, 40, 41, 1);
    #2;
    arst_n_in = 1'b0;
    #1;
    check_idle("rst.async");
    check("rst.in_ready", 128'(in_ready), 128'(1));
    #3;
    arst_n_in = 1'b1;
    step();
    check("rst.still_idle", 128'(out_valid), 128'(0));
    set_pix(1200, 5, 6);
    in_we = 1'b1;
    step();
    in_we = 1'b0;
    for (int b = 0; b < 6; b++) begin
      check_beat("rst.new", 1200, 5, 6, b);
      step();
    end
    check("rst.done", 128'(out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_drain_buffer.md
Name: output_drain_buffer

Overview:
- Downstream neighbour of the convolution controller FSM. Captures one pixel's full output-channel vector, with its x/y coordinates, when the output register is written.
- Buffers up to DEPTH such pixels and drains each one as LANES channels per beat to the output bus, under a valid/ready handshake.
- Decouples compute from output-bus backpressure and reports when it cannot accept a new pixel.

Parameters:
- NB_CHANNELS, 16, output channels per pixel
- LANES, 3, channels sent per output beat
- DATA_WIDTH, 32, bits per channel value
- DEPTH, 2, pixel entries buffered (power of 2, >=2)
- FEATURE_MAP_WIDTH, 128, x range
- FEATURE_MAP_HEIGHT, 128, y range

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous reset, active low
- clear  in  1  synchronous flush of all buffered state
- in_we  in  1  capture strobe (one pixel)
- in_data  in  NB_CHANNELS*DATA_WIDTH  channel vector; ch0 in the LSBs
- in_x  in  clog2(FEATURE_MAP_WIDTH)  pixel x
- in_y  in  clog2(FEATURE_MAP_HEIGHT)  pixel y
- in_ready  out  1  an entry is free
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts the beat
- out_data  out  LANES*DATA_WIDTH  lane i = channel out_ch+i
- out_lane_mask  out  LANES  lane i carries a real channel
- out_x  out  clog2(FEATURE_MAP_WIDTH)  x of the head pixel
- out_y  out  clog2(FEATURE_MAP_HEIGHT)  y of the head pixel
- out_ch  out  clog2(NB_CHANNELS)  first channel of the beat
- out_last  out  1  final beat of the pixel
- overflow  out  1  sticky: a capture was dropped

Behaviour:
- Reset: FIFO empty, beat counter 0, overflow 0. in_ready=1. out_valid, out_data, out_lane_mask, out_x, out_y, out_ch and out_last all 0.
- BEATS = ceil(NB_CHANNELS/LANES). With the defaults BEATS = 6 and out_ch runs 0,3,6,9,12,15.
- Push: occurs when in_we && in_ready. in_data, in_x and in_y are stored as one entry at the rising edge.
- Dropped capture: in_we while in_ready=0 does not store anything and sets overflow, which stays 1 until reset or clear.
- in_ready = !full. It does not look ahead at a same-cycle pop.
- Drain FSM, two states:
  - EMPTY: out_valid=0. Moves to SEND when the FIFO count becomes nonzero.
  - SEND: out_valid=1 and the head entry is presented.
- Latency: a push into an empty buffer raises out_valid on the next cycle (1-cycle latency).
- Beat counter b: out_ch = b*LANES. Lane i drives channel b*LANES+i if that is < NB_CHANNELS; otherwise the lane drives 0 with its mask bit 0.
- Lane mask values with the defaults: out_lane_mask = 3'b111 for beats 0..4 and 3'b001 on beat 5. out_last = (b == BEATS-1).
- Handshake: out_valid && out_ready advances b.
  - On the last beat the handshake pops the entry and resets b to 0.
  - The FSM then stays in SEND if entries remain (next pixel presented the next cycle, no bubble), else goes to EMPTY.
- Stability: while out_valid && !out_ready, every out_* signal holds stable. out_valid never drops without a handshake, except on clear or reset.
- Simultaneous push and pop, not full: both take effect and the count is unchanged.
- Push when full: not possible, since in_ready=0 and the capture is dropped as above.
- Pointer wrap-around: read and write pointers are clog2(DEPTH)+1 bits. Full = MSBs differ and lower bits equal.
- clear: empties the FIFO, resets b to 0, clears overflow, and forces EMPTY.
  - clear beats in_we and out handshake in the same cycle; no push or pop happens.
  - out_valid = 0 on the following cycle.
- Reset mid-drain: asynchronous return to the reset values; partially sent pixels are discarded.
- Width rules: out_ch = b*LANES computed at clog2(NB_CHANNELS) bits. BEATS*LANES may exceed NB_CHANNELS; masked lanes never index past in_data.

Decomposition:
- Shared package output_drain_pkg holds:
  - function beats(nb_channels, lanes) returning the ceiling divide;
  - function lane_mask(beat, nb_channels, lanes);
  - typedef enum {EMPTY, SEND} drain_state_e.
- Sub-module output_entry_fifo: a synchronous DEPTH-entry FIFO of width NB_CHANNELS*DATA_WIDTH + x + y bits.
  - Ports: push, pop, clear, full, empty, head data.
- The top level contains the drain FSM, the beat counter and the lane slicing.

Test Plan:
- Single push, out_ready=1 throughout:
  - Stimulus: in_data channel k = k+100, x=4, y=8.
  - Response: out_valid rises 1 cycle after the push. 6 consecutive beats with out_ch 0,3,6,9,12,15.
  - Beat 0 data = {102,101,100}. Beat 5 lane0 = 115, mask 3'b001, out_last=1. out_x=4, out_y=8 on all beats.
- Backpressure: out_ready=0 for 3 cycles during beat 2 -> out_ch=6 and its data held unchanged for those 3 cycles; beat 3 follows the first accepted cycle; still exactly 6 beats in total.
- Fill and overflow (DEPTH=2, out_ready=0):
  - Push 2 pixels -> in_ready=0.
  - Third in_we -> not stored, overflow=1.
  - Then out_ready=1 -> 12 beats carrying only the first two pixels' x/y.
- Back-to-back pixels:
  - Stimulus: push pixel A, then push pixel B in the same cycle as A's last-beat handshake.
  - Response: B's beat 0 appears the next cycle, with no idle cycle and no lost beat.
- clear during beat 3 with 2 entries queued -> next cycle out_valid=0, in_ready=1, overflow=0. A new push after that starts at out_ch=0.
- Assert arst_n_in mid-drain -> all outputs 0 immediately. After release, a fresh push drains correctly from beat 0.
